serv_bus_arbiter: RTL and testbench
===================================

SERV_BUS_ARBITER -- requirements
Module: serv_bus_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 512, meaning words of shared single-port system RAM (power of two).
REQ-002 SHALL have parameter MEM_REGION, default 8'h01, meaning adr[31:24] decoding to system RAM.
REQ-003 SHALL have parameter PER_REGION, default 8'h02, meaning adr[31:24] decoding to the peripheral port.
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have ports i_ibus_adr/i_ibus_cyc, input, 32/1, meaning the SERV instruction fetch request.
REQ-007 SHALL have ports o_ibus_rdt/o_ibus_ack, output, 32/1, meaning fetch data and a one-cycle ack.
REQ-008 SHALL have ports i_dbus_adr/i_dbus_dat/i_dbus_sel/i_dbus_we/i_dbus_cyc, input, 32/32/4/1/1, meaning the SERV data request.
REQ-009 SHALL have ports o_dbus_rdt/o_dbus_ack, output, 32/1, meaning load data and a one-cycle ack.
REQ-010 SHALL have ports o_mem_addr/o_mem_en/o_mem_we/o_mem_wdata, output, log2(MEM_WORDS)/1/4/32, meaning the RAM port, with the word address taken from adr[log2(MEM_WORDS)+1:2].
REQ-011 SHALL have port i_mem_rdata, input, 32, meaning RAM read data, valid one cycle after o_mem_en.
REQ-012 SHALL have ports o_per_adr/o_per_dat/o_per_sel/o_per_we/o_per_cyc, output, 24/32/4/1/1, and i_per_rdt/i_per_ack, input, 32/1, meaning the peripheral port.
REQ-013 SHALL have ports o_fault/o_fault_adr, output, 1/32, meaning a sticky unmapped-access flag and the offending address.

Function
REQ-014 SHALL implement states IDLE, MEM, RESP, ACK, PER and FAULT.
REQ-015 SHALL sample requests only in IDLE; cyc in any other state is ignored.
REQ-016 When both cyc are high in IDLE, SHALL grant round-robin: the requester not granted last wins; after reset, dbus wins.
REQ-017 SHALL route a granted MEM_REGION address to MEM: registered o_mem_en=1 for exactly one cycle, o_mem_we=sel when dbus_we else 0, o_mem_wdata=dat; ibus never writes.
REQ-018 SHALL sequence MEM->RESP->ACK: at the RESP->ACK edge, the granted o_*_rdt<=i_mem_rdata and o_*_ack<=1; ACK lasts one cycle with ack high, then IDLE with ack low.
REQ-019 SHALL acknowledge a RAM access on the third rising edge after the IDLE sampling edge, and SHALL not ack a requester that was not granted.
REQ-020 SHALL route PER_REGION to PER: o_per_cyc=1 with adr[23:0]/dat/sel/we held stable until i_per_ack; on that edge it registers rdt, pulses the requester ack, drops o_per_cyc, and enters ACK.
REQ-021 SHALL route any other region to FAULT: o_fault<=1, o_fault_adr<=adr, no ack (requester stalls); FAULT is terminal until reset.
REQ-022 SHALL hold o_*_rdt between accesses; writes ack with rdt unchanged.
REQ-023 SHALL ignore i_per_ack outside PER.

Reset
REQ-024 SHALL on i_reset_n low, asynchronously, force state IDLE, all acks/cyc/en/we to 0, rdt/wdata/addr/fault_adr to 0, o_fault to 0, and the round-robin pointer to "ibus last", including mid-access; an interrupted RAM write is not retried.

Structure
REQ-025 SHALL take the state enum, region constants and the default MEM_WORDS from package serv_bus_pkg.
REQ-026 SHALL place the two-way round-robin grant in sub-module serv_rr_arb2 (req[1:0], update strobe -> one-hot grant).

Verification
REQ-027 ibus fetch of 0x01000008 with RAM word2=0xDEADBEEF -> o_mem_addr=2, o_ibus_ack one cycle on the third edge, o_ibus_rdt=0xDEADBEEF.
REQ-028 dbus write 0x01000004, sel=4'b0010, dat=0x0000AB00 -> o_mem_we=4'b0010 for one cycle, dbus ack, no ibus ack.
REQ-029 both cyc rise together twice in succession -> grant order dbus, ibus, dbus, ibus.
REQ-030 dbus read 0x02000010 with the peripheral acking after 5 cycles, rdt=0x12345678 -> o_per_adr=0x000010, o_dbus_ack one cycle after i_per_ack, o_dbus_rdt=0x12345678.
REQ-031 ibus fetch of 0x03000000 -> o_fault=1, o_fault_adr=0x03000000, no ack for 100 cycles, a later dbus request not served.
REQ-032 i_reset_n low during MEM -> all outputs 0 immediately; after release, a new fetch completes normally.

Source files
------------

// File: rtl/serv_bus_pkg.sv
// rtl/serv_bus_pkg.sv - state encoding and address-map defaults for the SERV bus arbiter
package serv_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MEM   = 3'd1,
    ST_RESP  = 3'd2,
    ST_ACK   = 3'd3,
    ST_PER   = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  localparam int unsigned MEM_WORDS_DEFAULT  = 512;
  localparam logic [7:0]  MEM_REGION_DEFAULT = 8'h01;
  localparam logic [7:0]  PER_REGION_DEFAULT = 8'h02;

endpackage

// File: rtl/serv_rr_arb2.sv
// rtl/serv_rr_arb2.sv - two-way round-robin grant, index 0 = ibus, index 1 = dbus
module serv_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_gnt
);

  // last_q holds the index granted most recently; reset says "ibus last" so dbus wins first
  logic last_q;
  logic last_d;

  // Grant the lone requester, or on a tie the one that did not win last time
  always_comb begin
    o_gnt  = 2'b00;
    last_d = last_q;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = last_q ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
    if (i_update && (o_gnt != 2'b00)) begin
      last_d = o_gnt[1];
    end
  end

  // Remember the winner only when the arbiter actually commits to a grant
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/serv_bus_arbiter.sv
// rtl/serv_bus_arbiter.sv - shares one RAM port and one peripheral port between SERV ibus and dbus
module serv_bus_arbiter
  import serv_bus_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter logic [7:0]  MEM_REGION = MEM_REGION_DEFAULT,
  parameter logic [7:0]  PER_REGION = PER_REGION_DEFAULT
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [31:0]                  i_ibus_adr,
  input  logic                         i_ibus_cyc,
  output logic [31:0]                  o_ibus_rdt,
  output logic                         o_ibus_ack,
  input  logic [31:0]                  i_dbus_adr,
  input  logic [31:0]                  i_dbus_dat,
  input  logic [3:0]                   i_dbus_sel,
  input  logic                         i_dbus_we,
  input  logic                         i_dbus_cyc,
  output logic [31:0]                  o_dbus_rdt,
  output logic                         o_dbus_ack,
  output logic [$clog2(MEM_WORDS)-1:0] o_mem_addr,
  output logic                         o_mem_en,
  output logic [3:0]                   o_mem_we,
  output logic [31:0]                  o_mem_wdata,
  input  logic [31:0]                  i_mem_rdata,
  output logic [23:0]                  o_per_adr,
  output logic [31:0]                  o_per_dat,
  output logic [3:0]                   o_per_sel,
  output logic                         o_per_we,
  output logic                         o_per_cyc,
  input  logic [31:0]                  i_per_rdt,
  input  logic                         i_per_ack,
  output logic                         o_fault,
  output logic [31:0]                  o_fault_adr
);

  localparam int AW = $clog2(MEM_WORDS);

  state_e          state_q, state_d;
  logic            dbus_own_q, dbus_own_d;
  logic            is_write_q, is_write_d;
  logic            ibus_ack_q, ibus_ack_d;
  logic            dbus_ack_q, dbus_ack_d;
  logic [31:0]     ibus_rdt_q, ibus_rdt_d;
  logic [31:0]     dbus_rdt_q, dbus_rdt_d;
  logic            mem_en_q, mem_en_d;
  logic [3:0]      mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [23:0]     per_adr_q, per_adr_d;
  logic [31:0]     per_dat_q, per_dat_d;
  logic [3:0]      per_sel_q, per_sel_d;
  logic            per_we_q, per_we_d;
  logic            per_cyc_q, per_cyc_d;
  logic            fault_q, fault_d;
  logic [31:0]     fault_adr_q, fault_adr_d;

  logic [1:0]      arb_req;
  logic [1:0]      arb_gnt;
  logic            arb_update;
  logic [31:0]     req_adr;
  logic            req_we;
  logic            complete;
  logic [31:0]     rsp_rdt;

  // Requests are only visible to the arbiter while idle
  assign arb_req = (state_q == ST_IDLE) ? {i_dbus_cyc, i_ibus_cyc} : 2'b00;
  assign rsp_rdt = (state_q == ST_PER) ? i_per_rdt : i_mem_rdata;

  serv_rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (arb_req),
    .i_update  (arb_update),
    .o_gnt     (arb_gnt)
  );

  // Next-state and next-output logic: decode the winner's region, run the access, pulse the ack
  always_comb begin
    state_d     = state_q;
    dbus_own_d  = dbus_own_q;
    is_write_d  = is_write_q;
    ibus_ack_d  = 1'b0;
    dbus_ack_d  = 1'b0;
    ibus_rdt_d  = ibus_rdt_q;
    dbus_rdt_d  = dbus_rdt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    per_adr_d   = per_adr_q;
    per_dat_d   = per_dat_q;
    per_sel_d   = per_sel_q;
    per_we_d    = per_we_q;
    per_cyc_d   = per_cyc_q;
    fault_d     = fault_q;
    fault_adr_d = fault_adr_q;
    arb_update  = 1'b0;
    complete    = 1'b0;
    req_adr     = arb_gnt[1] ? i_dbus_adr : i_ibus_adr;
    req_we      = arb_gnt[1] & i_dbus_we;

    case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          arb_update = 1'b1;
          dbus_own_d = arb_gnt[1];
          is_write_d = req_we;
          if (req_adr[31:24] == MEM_REGION) begin
            state_d     = ST_MEM;
            mem_en_d    = 1'b1;
            mem_addr_d  = req_adr[AW+1:2];
            mem_we_d    = req_we ? i_dbus_sel : 4'b0000;
            mem_wdata_d = arb_gnt[1] ? i_dbus_dat : 32'h0;
          end else if (req_adr[31:24] == PER_REGION) begin
            state_d   = ST_PER;
            per_cyc_d = 1'b1;
            per_adr_d = req_adr[23:0];
            per_dat_d = arb_gnt[1] ? i_dbus_dat : 32'h0;
            per_sel_d = arb_gnt[1] ? i_dbus_sel : 4'hF;
            per_we_d  = req_we;
          end else begin
            state_d     = ST_FAULT;
            fault_d     = 1'b1;
            fault_adr_d = req_adr;
          end
        end
      end
      ST_MEM: begin
        mem_en_d = 1'b0;
        mem_we_d = 4'b0000;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        complete = 1'b1;
        state_d  = ST_ACK;
      end
      ST_PER: begin
        if (i_per_ack) begin
          complete  = 1'b1;
          per_cyc_d = 1'b0;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Writes acknowledge without disturbing the last read data
    if (complete) begin
      if (dbus_own_q) begin
        dbus_ack_d = 1'b1;
        if (!is_write_q) dbus_rdt_d = rsp_rdt;
      end else begin
        ibus_ack_d = 1'b1;
        if (!is_write_q) ibus_rdt_d = rsp_rdt;
      end
    end
  end

  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      dbus_own_q  <= 1'b0;
      is_write_q  <= 1'b0;
      ibus_ack_q  <= 1'b0;
      dbus_ack_q  <= 1'b0;
      ibus_rdt_q  <= 32'h0;
      dbus_rdt_q  <= 32'h0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      per_adr_q   <= 24'h0;
      per_dat_q   <= 32'h0;
      per_sel_q   <= 4'b0000;
      per_we_q    <= 1'b0;
      per_cyc_q   <= 1'b0;
      fault_q     <= 1'b0;
      fault_adr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      dbus_own_q  <= dbus_own_d;
      is_write_q  <= is_write_d;
      ibus_ack_q  <= ibus_ack_d;
      dbus_ack_q  <= dbus_ack_d;
      ibus_rdt_q  <= ibus_rdt_d;
      dbus_rdt_q  <= dbus_rdt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      per_adr_q   <= per_adr_d;
      per_dat_q   <= per_dat_d;
      per_sel_q   <= per_sel_d;
      per_we_q    <= per_we_d;
      per_cyc_q   <= per_cyc_d;
      fault_q     <= fault_d;
      fault_adr_q <= fault_adr_d;
    end
  end

  assign o_ibus_rdt  = ibus_rdt_q;
  assign o_ibus_ack  = ibus_ack_q;
  assign o_dbus_rdt  = dbus_rdt_q;
  assign o_dbus_ack  = dbus_ack_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_per_adr   = per_adr_q;
  assign o_per_dat   = per_dat_q;
  assign o_per_sel   = per_sel_q;
  assign o_per_we    = per_we_q;
  assign o_per_cyc   = per_cyc_q;
  assign o_fault     = fault_q;
  assign o_fault_adr = fault_adr_q;

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// tb/tb_serv_bus_arbiter.sv - self-checking bench for serv_bus_arbiter
module tb_serv_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  logic [8:0]  mem_addr;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [23:0] per_adr;
  logic [31:0] per_dat;
  logic [3:0]  per_sel;
  logic        per_we;
  logic        per_cyc;
  logic [31:0] per_rdt;
  logic        per_ack;
  logic        fault;
  logic [31:0] fault_adr;

  always #5 clk = ~clk;

  serv_bus_arbiter dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_ibus_adr  (ibus_adr),
    .i_ibus_cyc  (ibus_cyc),
    .o_ibus_rdt  (ibus_rdt),
    .o_ibus_ack  (ibus_ack),
    .i_dbus_adr  (dbus_adr),
    .i_dbus_dat  (dbus_dat),
    .i_dbus_sel  (dbus_sel),
    .i_dbus_we   (dbus_we),
    .i_dbus_cyc  (dbus_cyc),
    .o_dbus_rdt  (dbus_rdt),
    .o_dbus_ack  (dbus_ack),
    .o_mem_addr  (mem_addr),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_per_adr   (per_adr),
    .o_per_dat   (per_dat),
    .o_per_sel   (per_sel),
    .o_per_we    (per_we),
    .o_per_cyc   (per_cyc),
    .i_per_rdt   (per_rdt),
    .i_per_ack   (per_ack),
    .o_fault     (fault),
    .o_fault_adr (fault_adr)
  );

  // Single-port RAM: byte-enabled write, registered read
  logic [31:0] ram [0:511];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  int compared   = 0;
  int mismatched = 0;
  int ack_cnt    = 0;
  int en_cnt     = 0;

  typedef struct packed {
    logic        is_dbus;
    logic [31:0] rdt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest expected requester and its read data
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) en_cnt++;
      if (ibus_ack || dbus_ack) begin
        ack_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", {30'b0, dbus_ack, ibus_ack}, 32'h0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("ack_who", {30'b0, dbus_ack, ibus_ack}, mon_e.is_dbus ? 32'h2 : 32'h1);
          chk("ack_rdt", mon_e.is_dbus ? dbus_rdt : ibus_rdt, mon_e.rdt);
        end
      end
    end
  end

  task automatic access(input logic dbus, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we, input logic [31:0] exp_rdt,
                        input int exp_cycles);
    int   n;
    logic seen;
    exp_t e;
    n = 0;
    seen = 1'b0;
    e.is_dbus = dbus;
    e.rdt = exp_rdt;
    sb_q.push_back(e);
    if (dbus) begin
      dbus_adr = adr; dbus_dat = dat; dbus_sel = sel; dbus_we = we; dbus_cyc = 1'b1;
    end else begin
      ibus_adr = adr; ibus_cyc = 1'b1;
    end
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      seen = dbus ? dbus_ack : ibus_ack;
    end
    ibus_cyc = 1'b0;
    dbus_cyc = 1'b0;
    dbus_we  = 1'b0;
    chk("ack_latency", n, exp_cycles);
    @(negedge clk);
    chk("ack_pulse", {31'b0, dbus ? dbus_ack : ibus_ack}, 32'h0);
  endtask

  task automatic both_req(input logic [31:0] adr_d, input logic [31:0] exp_d,
                          input logic [31:0] adr_i, input logic [31:0] exp_i);
    int   n;
    exp_t e;
    n = 0;
    e.is_dbus = 1'b1; e.rdt = exp_d; sb_q.push_back(e);
    e.is_dbus = 1'b0; e.rdt = exp_i; sb_q.push_back(e);
    dbus_adr = adr_d; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_dat = 32'h0;
    ibus_adr = adr_i;
    dbus_cyc = 1'b1;
    ibus_cyc = 1'b1;
    while ((dbus_cyc || ibus_cyc) && n < 60) begin
      @(negedge clk);
      n++;
      if (dbus_ack) dbus_cyc = 1'b0;
      if (ibus_ack) ibus_cyc = 1'b0;
    end
    chk("rr_both_served", {30'b0, dbus_cyc, ibus_cyc}, 32'h0);
    @(negedge clk);
    chk("rr_sb_empty", sb_q.size(), 32'h0);
  endtask

  int   ack_snap;
  int   en_snap;
  exp_t ent;

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 32'h0;
    ram[0] = 32'hCAFEF00D;
    ram[1] = 32'h11223344;
    ram[2] = 32'hDEADBEEF;
    ram[3] = 32'h0BADC0DE;
    rst_n = 1'b0;
    ibus_adr = 32'h0; ibus_cyc = 1'b0;
    dbus_adr = 32'h0; dbus_dat = 32'h0; dbus_sel = 4'h0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    per_rdt = 32'h0; per_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {ibus_ack, dbus_ack, mem_en, mem_we, per_cyc, per_we, fault}, 32'h0);
    chk("reset_rdt", ibus_rdt | dbus_rdt | fault_adr | mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ibus fetch from RAM word 2, cycle by cycle
    ent.is_dbus = 1'b0; ent.rdt = 32'hDEADBEEF; sb_q.push_back(ent);
    ibus_adr = 32'h01000008; ibus_cyc = 1'b1;
    @(negedge clk);
    chk("fetch_en", {31'b0, mem_en}, 32'h1);
    chk("fetch_addr", {23'b0, mem_addr}, 32'h2);
    chk("fetch_we", {28'b0, mem_we}, 32'h0);
    @(negedge clk);
    chk("fetch_en_one_cycle", {31'b0, mem_en}, 32'h0);
    chk("fetch_no_early_ack", {31'b0, ibus_ack}, 32'h0);
    @(negedge clk);
    chk("fetch_ack", {31'b0, ibus_ack}, 32'h1);
    chk("fetch_rdt", ibus_rdt, 32'hDEADBEEF);
    ibus_cyc = 1'b0;
    @(negedge clk);
    chk("fetch_ack_drop", {31'b0, ibus_ack}, 32'h0);

    // dbus byte write to word 1
    en_snap = en_cnt;
    ent.is_dbus = 1'b1; ent.rdt = 32'h0; sb_q.push_back(ent);
    dbus_adr = 32'h01000004; dbus_dat = 32'h0000AB00; dbus_sel = 4'b0010; dbus_we = 1'b1; dbus_cyc = 1'b1;
    @(negedge clk);
    chk("write_we", {28'b0, mem_we}, 32'h2);
    chk("write_wdata", mem_wdata, 32'h0000AB00);
    chk("write_addr", {23'b0, mem_addr}, 32'h1);
    @(negedge clk);
    chk("write_we_drop", {28'b0, mem_we}, 32'h0);
    @(negedge clk);
    chk("write_acks", {30'b0, dbus_ack, ibus_ack}, 32'h2);
    chk("write_rdt_held", dbus_rdt, 32'h0);
    dbus_cyc = 1'b0; dbus_we = 1'b0;
    @(negedge clk);
    chk("write_en_count", en_cnt - en_snap, 32'h1);
    chk("write_ram", ram[1], 32'h1122AB44);

    // Read back the merged word over ibus
    access(1'b0, 32'h01000004, 32'h0, 4'h0, 1'b0, 32'h1122AB44, 3);

    // Simultaneous requests, twice: dbus, ibus, dbus, ibus
    both_req(32'h0100000C, 32'h0BADC0DE, 32'h01000000, 32'hCAFEF00D);
    both_req(32'h01000000, 32'hCAFEF00D, 32'h0100000C, 32'h0BADC0DE);

    // Peripheral read with a slow ack
    ent.is_dbus = 1'b1; ent.rdt = 32'h12345678; sb_q.push_back(ent);
    dbus_adr = 32'h02000010; dbus_dat = 32'h0; dbus_sel = 4'hF; dbus_we = 1'b0; dbus_cyc = 1'b1;
    @(negedge clk);
    chk("per_cyc", {31'b0, per_cyc}, 32'h1);
    chk("per_adr", {8'b0, per_adr}, 32'h000010);
    chk("per_we_sel", {27'b0, per_we, per_sel}, 32'h0F);
    repeat (4) @(negedge clk);
    chk("per_wait_no_ack", {30'b0, dbus_ack, per_cyc}, 32'h1);
    chk("per_adr_stable", {8'b0, per_adr}, 32'h000010);
    per_ack = 1'b1; per_rdt = 32'h12345678;
    @(negedge clk);
    per_ack = 1'b0; per_rdt = 32'h0;
    chk("per_ack_cyc", {30'b0, dbus_ack, per_cyc}, 32'h2);
    chk("per_rdt", dbus_rdt, 32'h12345678);
    dbus_cyc = 1'b0;
    @(negedge clk);
    chk("per_ack_drop", {31'b0, dbus_ack}, 32'h0);

    // Stray peripheral ack while idle
    ack_snap = ack_cnt;
    per_ack = 1'b1; per_rdt = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    per_ack = 1'b0; per_rdt = 32'h0;
    chk("stray_ack_ignored", ack_cnt - ack_snap, 32'h0);
    chk("stray_rdt_held", dbus_rdt, 32'h12345678);

    // Reset in the middle of a RAM access
    dbus_adr = 32'h01000008; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_cyc = 1'b1;
    @(negedge clk);
    chk("midreset_in_mem", {31'b0, mem_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {ibus_ack, dbus_ack, mem_en, mem_we, per_cyc, per_we, fault}, 32'h0);
    chk("midreset_addr", {23'b0, mem_addr}, 32'h0);
    chk("midreset_ibus_rdt", ibus_rdt, 32'h0);
    chk("midreset_dbus_rdt", dbus_rdt, 32'h0);
    chk("midreset_data", mem_wdata | fault_adr | {8'b0, per_adr} | per_dat, 32'h0);
    dbus_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    both_req(32'h01000008, 32'hDEADBEEF, 32'h01000004, 32'h1122AB44);

    // Unmapped fetch: sticky fault, no acks, later requests stall
    ack_snap = ack_cnt;
    ibus_adr = 32'h03000000; ibus_cyc = 1'b1;
    @(negedge clk);
    chk("fault_flag", {31'b0, fault}, 32'h1);
    chk("fault_adr", fault_adr, 32'h03000000);
    repeat (100) @(negedge clk);
    chk("fault_no_ack", ack_cnt - ack_snap, 32'h0);
    ibus_cyc = 1'b0;
    en_snap = en_cnt;
    dbus_adr = 32'h01000000; dbus_we = 1'b0; dbus_cyc = 1'b1;
    repeat (20) @(negedge clk);
    chk("fault_dbus_no_mem", en_cnt - en_snap, 32'h0);
    chk("fault_dbus_no_ack", ack_cnt - ack_snap, 32'h0);
    chk("fault_sticky", {31'b0, fault}, 32'h1);
    dbus_cyc = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
